// File: rtl/icache_responder_if.sv
// -----------------------------------------------------------------------------
// icache_responder_if
// Bundles the instruction-fetch side (datapath <-> cache) and the RAM side
// (cache <-> memory arbiter) of the direct-mapped instruction cache.
//   imemREN/imemaddr  : fetch request from the IF stage
//   ihit/imemload     : fetch answer to the IF stage
//   iREN/iaddr        : single-word read request to memory
//   iwait/iload       : memory busy flag and read data
//   inval             : one-cycle whole-cache invalidate pulse
// Modports: cache (the responder itself), master (datapath + memory side).
// -----------------------------------------------------------------------------
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        inval;

  modport cache (
    input  imemREN, imemaddr, iwait, iload, inval,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload, inval,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
// Direct-mapped, one-word-per-block instruction cache. Hits are answered
// combinationally in IDLE; a miss latches the word address and sits in FETCH
// issuing iREN until memory drops iwait, then fills the set and returns to
// IDLE where the request is looked up again.
// Ports:
//   CLK   : system clock
//   nRST  : synchronous active-low reset
//   cif   : icache_responder_if.cache (fetch port, memory port, inval)
// Parameters:
//   IDX_W : index bits (2**IDX_W sets)
//   TAG_W : tag bits, must equal 30 - IDX_W
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic               CLK,
  input  logic               nRST,
  icache_responder_if.cache  cif
);

  localparam int NSETS = 1 << IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [NSETS-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [NSETS];
  logic [31:0]       r_data [NSETS];
  logic [31:0]       r_miss_addr;

  logic [IDX_W-1:0]  w_req_idx;
  logic [TAG_W-1:0]  w_req_tag;
  logic [IDX_W-1:0]  w_miss_idx;
  logic [TAG_W-1:0]  w_miss_tag;
  logic              w_hit;
  logic              w_fill;
  logic              w_miss_latch;

  assign w_req_idx  = cif.imemaddr[IDX_W+1:2];
  assign w_req_tag  = cif.imemaddr[31:32-TAG_W];
  // The fill is addressed by the latched miss, never by the live fetch address,
  // so a datapath redirect during FETCH cannot corrupt another set.
  assign w_miss_idx = r_miss_addr[IDX_W+1:2];
  assign w_miss_tag = r_miss_addr[31:32-TAG_W];

  assign w_hit = cif.imemREN & r_valid[w_req_idx] & (r_tag[w_req_idx] == w_req_tag);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value held over from the previous evaluation and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_fill        = 1'b0;
    w_miss_latch  = 1'b0;
    cif.ihit      = 1'b0;
    cif.imemload  = '0;
    cif.iREN      = 1'b0;
    cif.iaddr     = '0;

    case (r_state)
      IDLE: begin
        if (w_hit) begin
          cif.ihit     = 1'b1;
          cif.imemload = r_data[w_req_idx];
        end else if (cif.imemREN) begin
          w_miss_latch = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        cif.iREN  = 1'b1;
        cif.iaddr = r_miss_addr;
        // inval takes priority over a completing fill: the returning word
        // belongs to a cache image that is being discarded.
        if (cif.inval) begin
          w_next_state = IDLE;
        end else if (!cif.iwait) begin
          w_fill       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase

    // Outputs are forced quiet for the whole time reset is held, not only
    // from the first edge that samples it.
    if (!nRST) begin
      cif.ihit     = 1'b0;
      cif.imemload = '0;
      cif.iREN     = 1'b0;
      cif.iaddr    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_miss_latch) r_miss_addr <= {cif.imemaddr[31:2], 2'b00};
    end
  end

  // inval clears every valid bit whatever the state; in IDLE the lookup for
  // this cycle has already used the old contents.
  always_ff @(posedge CLK) begin
    if (!nRST)            r_valid <= '0;
    else if (cif.inval)   r_valid <= '0;
    else if (w_fill)      r_valid[w_miss_idx] <= 1'b1;
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // decide whether their contents are ever used.
  always_ff @(posedge CLK) begin
    if (nRST && w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= cif.iload;
    end
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache that answers the datapath's fetch requests (imemREN, imemaddr) with ihit and imemload.
- On a miss it issues a single-word read to the memory controller/arbiter and blocks until the memory returns data.
- Sits between the pipeline's IF stage and the RAM-side instruction port, inside the caches wrapper of the datapath_cache_if / cache_control_if pair.

Parameters:
- IDX_W, 4, index bits; number of sets = 2**IDX_W (default 16 one-word blocks)
- TAG_W, 26, tag bits; must equal 30 - IDX_W

Ports:
- CLK  in  1  system clock
- nRST  in  1  synchronous active-low reset
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  datapath fetch byte address (word aligned)
- ihit  out  1  fetch satisfied this cycle; imemload valid
- imemload  out  32  instruction word
- iREN  out  1  read request to memory
- iaddr  out  32  memory read word address
- iwait  in  1  memory busy; data not yet valid
- iload  in  32  memory read data, valid when iREN=1 and iwait=0
- inval  in  1  one-cycle pulse: invalidate whole cache

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on nRST (sampled on the rising edge of CLK).
- Address split:
  - tag = imemaddr[31:32-TAG_W]
  - idx = imemaddr[IDX_W+1:2]
  - imemaddr[1:0] ignored
- Storage per set: valid (1), tag (TAG_W), data (32).
- Reset (nRST=0 at rising edge):
  - all valid bits cleared; state := IDLE; miss address register := 0
  - outputs during and after reset: ihit=0, iREN=0, iaddr=0, imemload=0
- States: IDLE, FETCH.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==tag).
  - On a hit: ihit=1 and imemload=data[idx], combinational, same cycle.
  - On imemREN & !hit: latch {imemaddr[31:2],2'b00} into the miss register; next state FETCH; ihit=0.
  - imemREN=0: ihit=0, imemload=0, stay IDLE.
- FETCH:
  - iREN=1; iaddr=miss register; ihit=0 regardless of imemaddr.
  - iwait=1: stay in FETCH.
  - iwait=0: write valid=1, tag and data=iload into set miss_idx; next state IDLE.
- Miss latency: the hit is reported in the first IDLE cycle after the fill. Total = 1 (detect) + memory cycles + 1 (lookup).
- Datapath redirect mid-fetch:
  - The fill always uses the latched miss address.
  - imemaddr or imemREN changes during FETCH do not abort the fill.
  - After returning to IDLE, the new address is looked up normally (it may miss again).
- inval:
  - In IDLE: all valid bits cleared at the edge; ihit still evaluates on the old contents in that same cycle.
  - In FETCH: aborts the fill (no array write); next state IDLE; iREN deasserts the next cycle.
  - inval and a fill completing (iwait=0) in the same cycle: inval wins; nothing is written.
- Replacement: the filled set is overwritten unconditionally. No write path from the datapath (self-modifying code is unsupported).
- iaddr is 0 whenever iREN=0.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000000, memory latency 2 (iwait=1,1,0), iload=0x3C010004:
  - iREN=1 for 3 cycles with iaddr=0x0
  - ihit=1, imemload=0x3C010004 on the following cycle
- Same address re-requested → ihit=1 the same cycle; iREN stays 0.
- Conflict: fill 0x00000040 (same idx 0, tag 1) with data 0xAAAA5555 → set 0 replaced.
  - Then 0x00000000 misses again: iREN=1, iaddr=0x0.
- Miss on 0x00000010; imemaddr changes to 0x00000080 during FETCH.
  - Fill writes idx 4 only.
  - Back in IDLE, 0x80 misses: new FETCH with iaddr=0x80.
- inval pulse during FETCH with iwait=0 in the same cycle:
  - no write; state IDLE; iREN=0 next cycle
  - re-request of the same address misses
- nRST=0 asserted mid-FETCH → next cycle iREN=0, ihit=0, iaddr=0; all previously filled addresses miss.
